// File: rtl/pll_lock_supervisor_pkg.sv
// Shared definitions for the PLL lock supervisor: FSM state encoding (also used by
// the telemetry decoder) and a counter-width helper.
package pll_lock_supervisor_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_READY     = 3'd3,
        ST_FAULT     = 3'd4
    } pls_state_t;

    // Width needed to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the lock supervisor (master) and the PLL / downstream reset
// logic (slave). The interface carries plain level signals; restart is a 1-cycle pulse.
interface pll_lock_supervisor_if
    import pll_lock_supervisor_pkg::*;
#(
    parameter int RETRY_W    = 2,
    parameter int LOSS_CNT_W = 8
) ();

    logic                  pll_locked;
    logic                  restart;
    logic                  pll_rst;
    logic                  pll_ready;
    logic                  fault;
    logic [RETRY_W-1:0]    retry_count;
    logic [LOSS_CNT_W-1:0] lock_loss_count;
    pls_state_t            state_o;

    modport master (
        input  pll_locked,
        input  restart,
        output pll_rst,
        output pll_ready,
        output fault,
        output retry_count,
        output lock_loss_count,
        output state_o
    );

    modport slave (
        output pll_locked,
        output restart,
        input  pll_rst,
        input  pll_ready,
        input  fault,
        input  retry_count,
        input  lock_loss_count,
        input  state_o
    );

endinterface

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop bit synchroniser; q follows d two clock edges later.
module pll_lock_supervisor_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: holds the PLL in reset, waits for a qualified lock with a
// per-attempt timeout, retries a bounded number of times, then latches a fault.
module pll_lock_supervisor
    import pll_lock_supervisor_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 50,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int STABLE_CYCLES       = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int LOSS_CNT_W          = 8
) (
    input logic                   refclk,
    input logic                   rst,
    pll_lock_supervisor_if.master bus
);

    localparam int HOLD_W  = cnt_w(RST_HOLD_CYCLES);
    localparam int TMO_W   = cnt_w(LOCK_TIMEOUT_CYCLES);
    localparam int STB_W   = cnt_w(STABLE_CYCLES);
    localparam int RETRY_W = cnt_w(MAX_RETRIES + 1);

    localparam logic [HOLD_W-1:0]     HOLD_LAST   = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [TMO_W-1:0]      TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [STB_W-1:0]      STB_LAST    = STB_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0]    RETRY_LAST  = RETRY_W'(MAX_RETRIES);
    localparam logic [LOSS_CNT_W-1:0] LOSS_SAT    = {LOSS_CNT_W{1'b1}};

    pls_state_t            state;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [TMO_W-1:0]      tmo_cnt;
    logic [STB_W-1:0]      stable_cnt;
    logic [RETRY_W-1:0]    retry_cnt;
    logic [LOSS_CNT_W-1:0] loss_cnt;
    logic                  locked_s;
    logic                  tmo_hit;
    logic                  retries_spent;

    pll_lock_supervisor_sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (bus.pll_locked),
        .q   (locked_s)
    );

    assign tmo_hit       = (tmo_cnt == TMO_LAST);
    assign retries_spent = (retry_cnt == RETRY_LAST);

    // Timeout takes precedence in WAIT_LOCK/STABILIZE so an attempt never exceeds
    // LOCK_TIMEOUT_CYCLES, even if lock is seen on the very last cycle.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state      <= ST_RESET_PLL;
            hold_cnt   <= '0;
            tmo_cnt    <= '0;
            stable_cnt <= '0;
            retry_cnt  <= '0;
            loss_cnt   <= '0;
        end else begin
            if (state == ST_READY && !locked_s && loss_cnt != LOSS_SAT) begin
                loss_cnt <= loss_cnt + LOSS_CNT_W'(1);
            end

            if (bus.restart) begin
                state     <= ST_RESET_PLL;
                hold_cnt  <= '0;
                retry_cnt <= '0;
            end else begin
                case (state)
                    ST_RESET_PLL: begin
                        tmo_cnt <= '0;
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            state    <= ST_WAIT_LOCK;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end

                    ST_WAIT_LOCK: begin
                        if (tmo_hit) begin
                            hold_cnt <= '0;
                            if (retries_spent) begin
                                state <= ST_FAULT;
                            end else begin
                                retry_cnt <= retry_cnt + RETRY_W'(1);
                                state     <= ST_RESET_PLL;
                            end
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                            if (locked_s) begin
                                stable_cnt <= '0;
                                state      <= ST_STABILIZE;
                            end
                        end
                    end

                    ST_STABILIZE: begin
                        if (tmo_hit) begin
                            hold_cnt <= '0;
                            if (retries_spent) begin
                                state <= ST_FAULT;
                            end else begin
                                retry_cnt <= retry_cnt + RETRY_W'(1);
                                state     <= ST_RESET_PLL;
                            end
                        end else begin
                            // tmo_cnt keeps running across a drop back to WAIT_LOCK
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                            if (!locked_s) begin
                                state <= ST_WAIT_LOCK;
                            end else if (stable_cnt == STB_LAST) begin
                                state <= ST_READY;
                            end else begin
                                stable_cnt <= stable_cnt + STB_W'(1);
                            end
                        end
                    end

                    ST_READY: begin
                        if (!locked_s) begin
                            hold_cnt  <= '0;
                            retry_cnt <= '0;
                            state     <= ST_RESET_PLL;
                        end
                    end

                    ST_FAULT: begin
                        state <= ST_FAULT;
                    end

                    default: begin
                        hold_cnt <= '0;
                        state    <= ST_RESET_PLL;
                    end
                endcase
            end
        end
    end

    assign bus.pll_rst         = (state == ST_RESET_PLL) || (state == ST_FAULT);
    assign bus.pll_ready       = (state == ST_READY);
    assign bus.fault           = (state == ST_FAULT);
    assign bus.retry_count     = retry_cnt;
    assign bus.lock_loss_count = loss_cnt;
    assign bus.state_o         = state;

endmodule
